// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding, default timing, counter sizing.
// Pure declarations; no latency or backpressure of its own.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    STAGGER = 3'd1,
    RUN     = 3'd2,
    QUIESCE = 3'd3,
    ASSERT  = 3'd4
  } state_t;

  localparam int DEF_NUM_DOMAINS     = 3;
  localparam int DEF_SYNC_DEPTH      = 3;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_STAGGER_CYCLES  = 4;
  localparam int DEF_QUIESCE_TIMEOUT = 64;
  localparam int DEF_WDT_CYCLES      = 1024;

  // Wide enough to hold max_val itself: ceil(log2(max_val)) + 1 bits.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_async_n.sv
// Active-low reset synchronizer: asserts asynchronously, deasserts DEPTH clock edges after reset_n rises.
// No flow control; output is a plain level.
module reset_sync_async_n #(
  parameter int DEPTH = 3
) (
  input  logic clock,
  input  logic reset_n,
  output logic rst_sync_n
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release with quiesced software partial resets; domain resets are registered.
// Optional watchdog enabled by RST_SEQ_WDT_EN; requests arriving outside RUN are dropped, not queued.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = DEF_NUM_DOMAINS,
  parameter int SYNC_DEPTH      = DEF_SYNC_DEPTH,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT,
  parameter int WDT_CYCLES      = DEF_WDT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   sw_reset_req,
  input  logic [NUM_DOMAINS-1:0] sw_reset_mask,
  output logic                   quiesce_req,
  input  logic                   quiesce_ack,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   all_released,
  output logic                   busy,
  output logic                   quiesce_timeout,
  output logic                   wdt_fired
);

  localparam int CNT_MAX = max_int(max_int(HOLD_CYCLES, STAGGER_CYCLES),
                                   max_int(QUIESCE_TIMEOUT, WDT_CYCLES));
  localparam int CW = cnt_width(CNT_MAX);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t HOLD_LAST    = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t STAGGER_LAST = cnt_t'(STAGGER_CYCLES - 1);
  localparam cnt_t QUIESCE_LAST = cnt_t'(QUIESCE_TIMEOUT - 1);

  logic rst_sync_n;

  reset_sync_async_n #(
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .rst_sync_n (rst_sync_n)
  );

  state_t                 state_q, state_d;
  cnt_t                   cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] target_q, target_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   qto_q, qto_d;

  logic [NUM_DOMAINS-1:0] pending;
  logic [NUM_DOMAINS-1:0] release_vec;
  logic                   last_release;
  logic                   sw_take;
  logic                   wdt_fire;

  // Lowest-index targeted domain still in reset, isolated as a one-hot vector.
  assign pending      = target_q & ~dom_q;
  assign release_vec  = pending & (~pending + 1'b1);
  assign last_release = (pending & ~release_vec) == '0;

  assign sw_take = (state_q == RUN) && sw_reset_req && (|sw_reset_mask);

`ifdef RST_SEQ_WDT_EN
  localparam cnt_t WDT_LAST = cnt_t'(WDT_CYCLES - 1);

  cnt_t wdt_cnt_q;
  logic wdt_fired_q;
  logic wdt_expire;

  assign wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);
  // A software request in the same cycle wins over the watchdog.
  assign wdt_fire   = wdt_expire && !sw_take;

  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      if ((state_q != RUN) || wdt_kick || wdt_expire) begin
        wdt_cnt_q <= '0;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + 1'b1;
      end
      if (wdt_fire) begin
        wdt_fired_q <= 1'b1;
      end
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  logic wdt_kick_unused;

  assign wdt_kick_unused = wdt_kick;
  assign wdt_fire        = 1'b0;
  assign wdt_fired       = 1'b0;
`endif

  // Power-on state: everything targeted and held, counter cleared until the synchronizer lets go.
  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      target_q <= '1;
      dom_q    <= '0;
      qto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      dom_q    <= dom_d;
      qto_q    <= qto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    dom_d    = dom_q;
    qto_d    = qto_q;

    unique case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          dom_d   = dom_q | release_vec;
          cnt_d   = '0;
          state_d = last_release ? RUN : STAGGER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STAGGER: begin
        if (cnt_q == STAGGER_LAST) begin
          dom_d   = dom_q | release_vec;
          cnt_d   = '0;
          state_d = last_release ? RUN : STAGGER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (sw_take) begin
          target_d = sw_reset_mask;
          cnt_d    = '0;
          state_d  = QUIESCE;
        end else if (wdt_fire) begin
          target_d = '1;
          cnt_d    = '0;
          state_d  = ASSERT;
        end
      end

      QUIESCE: begin
        // Ack is checked first so a coincident timeout does not flag.
        if (quiesce_ack) begin
          cnt_d   = '0;
          state_d = ASSERT;
        end else if (cnt_q == QUIESCE_LAST) begin
          qto_d   = 1'b1;
          cnt_d   = '0;
          state_d = ASSERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ASSERT: begin
        dom_d   = dom_q & ~target_q;
        cnt_d   = '0;
        state_d = HOLD;
      end

      default: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
    endcase
  end

  assign domain_reset_n  = dom_q;
  assign quiesce_req     = (state_q == QUIESCE);
  assign all_released    = (state_q == RUN);
  assign busy            = (state_q != RUN);
  assign quiesce_timeout = qto_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output-change events are queued with their clock edge.
// Covers power-on timing, partial reset with ack, ignored requests, quiesce timeout, async abort and watchdog.
module tb_reset_sequencer;

  localparam int N = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         sw_reset_req = 1'b0;
  logic [N-1:0] sw_reset_mask = '0;
  logic         quiesce_ack = 1'b0;
  logic         wdt_kick = 1'b0;
  logic         quiesce_req;
  logic [N-1:0] domain_reset_n;
  logic         all_released;
  logic         busy;
  logic         quiesce_timeout;
  logic         wdt_fired;

  reset_sequencer #(
    .NUM_DOMAINS     (3),
    .SYNC_DEPTH      (3),
    .HOLD_CYCLES     (16),
    .STAGGER_CYCLES  (4),
    .QUIESCE_TIMEOUT (64),
    .WDT_CYCLES      (1024)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .sw_reset_req    (sw_reset_req),
    .sw_reset_mask   (sw_reset_mask),
    .quiesce_req     (quiesce_req),
    .quiesce_ack     (quiesce_ack),
    .wdt_kick        (wdt_kick),
    .domain_reset_n  (domain_reset_n),
    .all_released    (all_released),
    .busy            (busy),
    .quiesce_timeout (quiesce_timeout),
    .wdt_fired       (wdt_fired)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Flags are {wdt_fired, quiesce_timeout, quiesce_req, busy, all_released}.
  function automatic logic [7:0] mk(input logic [2:0] dom, input logic [4:0] f);
    return {f, dom};
  endfunction

  logic [7:0] obs;
  assign obs = {wdt_fired, quiesce_timeout, quiesce_req, busy, all_released, domain_reset_n};

  localparam logic [7:0] RST_OBS = 8'b00010_000;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      tag;
  } ev_t;

  ev_t sb[$];

  task automatic expect_ev(input string tag, input int c, input logic [7:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  logic       mon_en = 1'b0;
  logic [7:0] prev_obs;

  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (mon_en && (obs !== prev_obs)) begin
        if (sb.size() == 0) begin
          check("spurious_event", {24'd0, obs}, {24'd0, prev_obs});
        end else begin
          e = sb.pop_front();
          check(e.tag, {24'd0, obs}, {24'd0, e.val});
          check({e.tag, "_cyc"}, cyc, e.cyc);
        end
        prev_obs = obs;
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic push_power_on(input int c0);
    expect_ev("po_d0",  c0 + 19, mk(3'b001, 5'b00010));
    expect_ev("po_d1",  c0 + 23, mk(3'b011, 5'b00010));
    expect_ev("po_run", c0 + 27, mk(3'b111, 5'b00001));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  int c0;
  int n;

  initial begin
    #2 reset_n = 1'b0;
    #1 check("reset_state", {24'd0, obs}, {24'd0, RST_OBS});
    prev_obs = obs;
    mon_en   = 1'b1;

    // Power-on release, with a request during STAGGER that must be dropped.
    @(negedge clock);
    wait_cyc(3);
    c0 = cyc;
    push_power_on(c0);
    reset_n = 1'b1;
    wait_cyc(c0 + 20);
    sw_reset_req  = 1'b1;
    sw_reset_mask = 3'b111;
    wait_cyc(c0 + 22);
    sw_reset_req  = 1'b0;
    sw_reset_mask = '0;
    wait_cyc(c0 + 30);
    check("po_drain", sb.size(), 0);

    // Partial reset of domains 1 and 2, acked after five quiesce cycles.
    n = cyc;
    expect_ev("pa_qreq",   n + 1,  mk(3'b111, 5'b00110));
    expect_ev("pa_qdrop",  n + 6,  mk(3'b111, 5'b00010));
    expect_ev("pa_assert", n + 7,  mk(3'b001, 5'b00010));
    expect_ev("pa_d1",     n + 23, mk(3'b011, 5'b00010));
    expect_ev("pa_run",    n + 27, mk(3'b111, 5'b00001));
    sw_reset_req  = 1'b1;
    sw_reset_mask = 3'b110;
    wait_cyc(n + 1);
    sw_reset_req  = 1'b0;
    sw_reset_mask = 3'b111;
    wait_cyc(n + 5);
    quiesce_ack = 1'b1;
    wait_cyc(n + 6);
    quiesce_ack   = 1'b0;
    sw_reset_mask = '0;
    wait_cyc(n + 30);
    check("pa_drain", sb.size(), 0);

    // Empty-mask request and stray ack in RUN: nothing may change.
    n = cyc;
    sw_reset_req = 1'b1;
    quiesce_ack  = 1'b1;
    wait_cyc(n + 10);
    sw_reset_req = 1'b0;
    quiesce_ack  = 1'b0;
    check("m0_qreq", quiesce_req, 0);
    check("m0_all_released", all_released, 1);
    wait_cyc(n + 12);
    check("m0_drain", sb.size(), 0);

    // Quiesce timeout on domain 1.
    n = cyc;
    expect_ev("to_qreq",   n + 1,  mk(3'b111, 5'b00110));
    expect_ev("to_fire",   n + 65, mk(3'b111, 5'b01010));
    expect_ev("to_assert", n + 66, mk(3'b101, 5'b01010));
    expect_ev("to_run",    n + 82, mk(3'b111, 5'b01001));
    sw_reset_req  = 1'b1;
    sw_reset_mask = 3'b010;
    wait_cyc(n + 1);
    sw_reset_req  = 1'b0;
    sw_reset_mask = '0;
    wait_cyc(n + 90);
    check("to_drain", sb.size(), 0);
    check("to_sticky", quiesce_timeout, 1);

    // Full partial reset, then abort with reset_n in the middle of STAGGER.
    n = cyc;
    expect_ev("ab_qreq",   n + 1,  mk(3'b111, 5'b01110));
    expect_ev("ab_qdrop",  n + 2,  mk(3'b111, 5'b01010));
    expect_ev("ab_assert", n + 3,  mk(3'b000, 5'b01010));
    expect_ev("ab_d0",     n + 19, mk(3'b001, 5'b01010));
    sw_reset_req  = 1'b1;
    sw_reset_mask = 3'b111;
    wait_cyc(n + 1);
    sw_reset_req = 1'b0;
    quiesce_ack  = 1'b1;
    wait_cyc(n + 2);
    quiesce_ack   = 1'b0;
    sw_reset_mask = '0;
    wait_cyc(n + 21);
    expect_ev("ab_reset", n + 22, RST_OBS);
    #2 reset_n = 1'b0;
    #1 check("abort_imm", {24'd0, obs}, {24'd0, RST_OBS});
    @(negedge clock);
    wait_cyc(n + 25);
    c0 = cyc;
    push_power_on(c0);
    reset_n = 1'b1;
    wait_cyc(c0 + 30);
    check("ab_drain", sb.size(), 0);

`ifdef RST_SEQ_WDT_EN
    // Watchdog: three kicks 1000 cycles apart hold it off, then it expires.
    n = c0 + 27;
    expect_ev("wd_fire",   n + 4025, mk(3'b111, 5'b10010));
    expect_ev("wd_assert", n + 4026, mk(3'b000, 5'b10010));
    expect_ev("wd_d0",     n + 4042, mk(3'b001, 5'b10010));
    expect_ev("wd_d1",     n + 4046, mk(3'b011, 5'b10010));
    expect_ev("wd_run",    n + 4050, mk(3'b111, 5'b10001));
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(n + 1000 * k);
      wdt_kick = 1'b1;
      wait_cyc(n + 1000 * k + 1);
      wdt_kick = 1'b0;
    end
    wait_cyc(n + 4020);
    check("wd_not_early", wdt_fired, 0);
    wait_cyc(n + 4053);
    check("wd_drain", sb.size(), 0);
`endif

    check("sb_final", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
